con_eval_unit: RTL and testbench

Parametrised, pipelined branch-condition evaluator for the datapath control path. It replaces the single-bit condition flip-flop with a 3-bit condition field, a stored ALU flag register (N, Z, C, V), a registered CON result with a valid strobe, and a saturating taken-branch counter. The control unit asserts CONin during the branch step. CONout/CONvalid feed the PC-load decision two clocks later.

---
 rtl/con_eval_unit_if.sv | 28 ++
 rtl/con_eval_unit.sv | 101 ++++++++++
 tb/tb_con_eval_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/con_eval_unit_if.sv
// Condition-evaluator bus: evaluate request, operand, condition select, ALU flags in;
// registered result, valid strobe, busy, flag register and taken counter out.
interface con_eval_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  CONin;
  logic [DATA_WIDTH-1:0] BusMuxOut;
  logic [2:0]            IrBits;
  logic [3:0]            FlagsIn;
  logic                  FlagsWe;
  logic                  count_clr;
  logic                  CONout;
  logic                  CONvalid;
  logic                  busy;
  logic [3:0]            flags;
  logic [CNT_WIDTH-1:0]  taken_count;

  modport master (
    output CONin, BusMuxOut, IrBits, FlagsIn, FlagsWe, count_clr,
    input  CONout, CONvalid, busy, flags, taken_count
  );

  modport slave (
    input  CONin, BusMuxOut, IrBits, FlagsIn, FlagsWe, count_clr,
    output CONout, CONvalid, busy, flags, taken_count
  );
endinterface

// File: rtl/con_eval_unit.sv
// Two-stage branch-condition evaluator: CONin at edge k gives CONvalid/CONout after edge k+1.
// No backpressure: one request accepted per clock, results strobed out in order.
module con_eval_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clock,
  input logic              reset_n,
  con_eval_unit_if.slave   cu
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Stage-1 capture
  logic       s1_valid;
  logic       s1_zero;
  logic       s1_msb;
  logic [2:0] s1_sel;
  logic [3:0] s1_flags;

  // Architectural state
  logic [3:0]           flag_q;
  logic                 con_q;
  logic                 con_vld_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic cond;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 4'b0000;
    end else if (cu.FlagsWe) begin
      flag_q <= cu.FlagsIn;
    end
  end

  // Operand data only loads with CONin, so idle-cycle X never enters the pipe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_msb   <= 1'b0;
      s1_sel   <= 3'b000;
      s1_flags <= 4'b0000;
    end else begin
      s1_valid <= cu.CONin;
      if (cu.CONin) begin
        s1_zero  <= (cu.BusMuxOut == '0);
        s1_msb   <= cu.BusMuxOut[DATA_WIDTH-1];
        s1_sel   <= cu.IrBits;
        s1_flags <= flag_q;
      end
    end
  end

  // s1_flags is {N,Z,C,V}
  always_comb begin
    cond = 1'b0;
    case (s1_sel)
      3'b000:  cond = s1_zero;
      3'b001:  cond = !s1_zero;
      3'b010:  cond = !s1_msb;
      3'b011:  cond = s1_msb;
      3'b100:  cond = 1'b1;
      3'b101:  cond = 1'b0;
      3'b110:  cond = !s1_flags[2] && (s1_flags[3] == s1_flags[0]);
      3'b111:  cond = !s1_flags[1];
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      con_q     <= 1'b0;
      con_vld_q <= 1'b0;
    end else begin
      con_vld_q <= s1_valid;
      if (s1_valid) begin
        con_q <= cond;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cu.count_clr) begin
      cnt_q <= '0;
    end else if (s1_valid && cond && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cu.CONout      = con_q;
  assign cu.CONvalid    = con_vld_q;
  assign cu.busy        = s1_valid;
  assign cu.flags       = flag_q;
  assign cu.taken_count = cnt_q;

endmodule

// File: tb/tb_con_eval_unit.sv
// Bench for con_eval_unit: three instances (default, 2-bit counter, 8-bit data) on shared stimulus,
// checked every cycle against a request-level model plus hand-computed literals.
module tb_con_eval_unit;

  logic        clock;
  logic        reset_n;
  logic        conin;
  logic [31:0] bus;
  logic [2:0]  sel;
  logic [3:0]  fin;
  logic        fwe;
  logic        clr;

  int vec;
  int errs;

  con_eval_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) if0 ();
  con_eval_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  if1 ();
  con_eval_unit_if #(.DATA_WIDTH(8),  .CNT_WIDTH(16)) if2 ();

  assign if0.CONin = conin;  assign if1.CONin = conin;  assign if2.CONin = conin;
  assign if0.BusMuxOut = bus; assign if1.BusMuxOut = bus; assign if2.BusMuxOut = bus[7:0];
  assign if0.IrBits = sel;   assign if1.IrBits = sel;   assign if2.IrBits = sel;
  assign if0.FlagsIn = fin;  assign if1.FlagsIn = fin;  assign if2.FlagsIn = fin;
  assign if0.FlagsWe = fwe;  assign if1.FlagsWe = fwe;  assign if2.FlagsWe = fwe;
  assign if0.count_clr = clr; assign if1.count_clr = clr; assign if2.count_clr = clr;

  con_eval_unit #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u0 (.clock(clock), .reset_n(reset_n), .cu(if0));
  con_eval_unit #(.DATA_WIDTH(32), .CNT_WIDTH(2))  u1 (.clock(clock), .reset_n(reset_n), .cu(if1));
  con_eval_unit #(.DATA_WIDTH(8),  .CNT_WIDTH(16)) u2 (.clock(clock), .reset_n(reset_n), .cu(if2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- request-level model ----------------
  int         dw   [3] = '{32, 32, 8};
  int         cmax [3] = '{65535, 3, 65535};
  bit         m_pend [3];
  bit         m_res  [3];
  bit         m_out  [3];
  bit         m_vld  [3];
  int         m_cnt  [3];
  logic [3:0] m_flags;

  function automatic bit cond_of(input logic [2:0] s, input logic [31:0] v, input int w,
                                 input logic [3:0] f);
    logic [31:0] m;
    bit msb;
    m   = (w >= 32) ? v : (v & ((32'd1 << w) - 32'd1));
    msb = m[w-1];
    case (s)
      3'd0: return m == 32'd0;
      3'd1: return m != 32'd0;
      3'd2: return !msb;
      3'd3: return msb;
      3'd4: return 1'b1;
      3'd5: return 1'b0;
      3'd6: return (f[2] == 1'b0) && (f[3] == f[0]);
      default: return f[1] == 1'b0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 0; m_res[i] = 0; m_out[i] = 0; m_vld[i] = 0; m_cnt[i] = 0;
      end
      m_flags = 4'b0000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_vld[i] = m_pend[i];
        if (m_pend[i]) m_out[i] = m_res[i];
        if (clr) m_cnt[i] = 0;
        else if (m_pend[i] && m_res[i] && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
        m_pend[i] = conin;
        if (conin) m_res[i] = cond_of(sel, bus, dw[i], m_flags);
      end
      if (fwe) m_flags = fin;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic vld, input logic out, input logic bsy,
                          input logic [3:0] fl, input int cnt);
    chk($sformatf("u%0d.CONvalid", i), int'(vld), int'(m_vld[i]));
    chk($sformatf("u%0d.CONout", i), int'(out), int'(m_out[i]));
    chk($sformatf("u%0d.busy", i), int'(bsy), int'(m_pend[i]));
    chk($sformatf("u%0d.flags", i), int'(fl), int'(m_flags));
    chk($sformatf("u%0d.taken_count", i), cnt, m_cnt[i]);
  endtask

  always @(negedge clock) begin
    chk_inst(0, if0.CONvalid, if0.CONout, if0.busy, if0.flags, int'(if0.taken_count));
    chk_inst(1, if1.CONvalid, if1.CONout, if1.busy, if1.flags, int'(if1.taken_count));
    chk_inst(2, if2.CONvalid, if2.CONout, if2.busy, if2.flags, int'(if2.taken_count));
  end

  // ---------------- directed stimulus ----------------
  int outq[$];
  int satq[$];
  int out8q[$];

  task automatic step(input logic c, input logic [2:0] s, input logic [31:0] b,
                      input logic we, input logic [3:0] f, input logic cl);
    conin = c; sel = s; bus = b; fwe = we; fin = f; clr = cl;
    @(posedge clock);
    #1;
    if (if0.CONvalid) outq.push_back(int'(if0.CONout));
    if (if1.CONvalid) satq.push_back(int'(if1.taken_count));
    if (if2.CONvalid) out8q.push_back(int'(if2.CONout));
  endtask

  task automatic idle();
    step(1'b0, 3'bxxx, 32'hxxxx_xxxx, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic chk_q(input string name, input int q[$], input int exp[$]);
    chk({name, ".len"}, q.size(), exp.size());
    for (int i = 0; i < q.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d]", name, i), q[i], exp[i]);
  endtask

  int base;

  initial begin
    vec = 0; errs = 0;
    reset_n = 1'b0; conin = 1'b0; sel = 3'b000; bus = 32'd0; fwe = 1'b0; fin = 4'd0; clr = 1'b0;
    #2;
    chk("reset.CONout", int'(if0.CONout), 0);
    chk("reset.busy", int'(if0.busy), 0);
    #10 reset_n = 1'b1;

    // Zero test
    step(1'b1, 3'b000, 32'd0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 3'b000, 32'd0, 1'b0, 4'd0, 1'b0);
    chk("zero.CONvalid", int'(if0.CONvalid), 1);
    chk("zero.CONout", int'(if0.CONout), 1);
    chk("zero.taken_count", int'(if0.taken_count), 1);
    idle();

    // Sign and zero codes back-to-back
    outq.delete();
    base = int'(if0.taken_count);
    step(1'b1, 3'b001, 32'h0000_0000, 1'b0, 4'd0, 1'b0);
    step(1'b1, 3'b010, 32'h7FFF_FFFF, 1'b0, 4'd0, 1'b0);
    step(1'b1, 3'b011, 32'h7FFF_FFFF, 1'b0, 4'd0, 1'b0);
    step(1'b1, 3'b011, 32'h8000_0000, 1'b0, 4'd0, 1'b0);
    idle(); idle();
    chk_q("b2b.CONout", outq, '{0, 1, 0, 1});
    chk("b2b.taken_delta", int'(if0.taken_count) - base, 2);

    // Flag hazard
    outq.delete();
    step(1'b1, 3'b110, 32'd0, 1'b1, 4'b0100, 1'b0);
    step(1'b1, 3'b110, 32'd0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 3'b000, 32'd0, 1'b1, 4'b0010, 1'b0);
    step(1'b1, 3'b111, 32'd0, 1'b0, 4'b0000, 1'b0);
    idle(); idle();
    chk_q("flags.CONout", outq, '{1, 0, 0});
    chk("flags.reg", int'(if0.flags), 4'b0010);

    // Saturation on the 2-bit counter
    step(1'b0, 3'b000, 32'd0, 1'b0, 4'd0, 1'b1);
    satq.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 3'b100, 32'd0, 1'b0, 4'd0, 1'b0);
    idle();
    chk_q("sat.taken_count", satq, '{1, 2, 3, 3, 3});

    // Clear against a same-cycle taken result
    step(1'b1, 3'b100, 32'd0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 3'b000, 32'd0, 1'b0, 4'd0, 1'b1);
    chk("clr.CONvalid", int'(if1.CONvalid), 1);
    chk("clr.taken_count_u1", int'(if1.taken_count), 0);
    chk("clr.taken_count_u0", int'(if0.taken_count), 0);

    // Reset mid-operation
    step(1'b1, 3'b100, 32'd0, 1'b0, 4'd0, 1'b0);
    chk("midrst.busy_before", int'(if0.busy), 1);
    chk("midrst.CONout_before", int'(if0.CONout), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst.busy", int'(if0.busy), 0);
    chk("midrst.CONout", int'(if0.CONout), 0);
    chk("midrst.flags", int'(if0.flags), 0);
    #2 reset_n = 1'b1;
    idle();
    chk("midrst.no_CONvalid", int'(if0.CONvalid), 0);
    idle();

    // Narrow datapath: upper bus bits are invisible to the 8-bit instance
    out8q.delete();
    outq.delete();
    step(1'b1, 3'b011, 32'h0000_0080, 1'b0, 4'd0, 1'b0);
    step(1'b1, 3'b000, 32'h0000_0000, 1'b0, 4'd0, 1'b0);
    step(1'b1, 3'b000, 32'h0000_0100, 1'b0, 4'd0, 1'b0);
    idle(); idle();
    chk_q("dw8.CONout", out8q, '{1, 1, 1});
    chk_q("dw32.CONout", outq, '{0, 1, 0});

    idle(); idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
